operand_sel_pipe: RTL and testbench
===================================

OPERAND_SEL_PIPE -- requirements
Module: operand_sel_pipe

Interface
REQ-001 Parameter NUM_INPUTS, default 3: number of selectable operand sources (range 2..16).
REQ-002 Parameter DATA_WIDTH, default 32: width of each operand.
REQ-003 Parameter SEL_W, default $clog2(NUM_INPUTS) with a minimum of 1: select width.
REQ-004 Parameter ERR_CNT_W, default 8: width of the error counter.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1: reset is synchronous and active-low.
REQ-007 Port in_data, input, NUM_INPUTS*DATA_WIDTH: packed operands; source k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port in_sel, input, SEL_W: binary source index.
REQ-009 Port in_valid, input, 1: upstream beat present.
REQ-010 Port in_ready, output, 1: block can accept a beat.
REQ-011 Port out_data, output, DATA_WIDTH: selected operand.
REQ-012 Port out_sel_err, output, 1: the beat's in_sel was >= NUM_INPUTS.
REQ-013 Port out_valid, output, 1: downstream beat present.
REQ-014 Port out_ready, input, 1: downstream accepts.
REQ-015 Port err_clr, input, 1: synchronous clear of err_count.
REQ-016 Port err_count, output, ERR_CNT_W: saturating count of accepted bad-select beats.

Function
REQ-017 Input handshake: a beat SHALL be accepted when in_valid && in_ready; output handshake: a beat SHALL retire when out_valid && out_ready.
REQ-018 Selection: for in_sel < NUM_INPUTS the beat data SHALL be slice in_sel, with sel_err = 0; otherwise data SHALL be all-zero, with sel_err = 1.
REQ-019 Selection and sel_err SHALL be evaluated at acceptance time; later changes to in_data/in_sel SHALL NOT affect stored beats.
REQ-020 Storage: an output register plus one skid register; the state machine SHALL have EMPTY (0 beats), ONE (output register valid), and FULL (output and skid registers valid).
REQ-021 Transitions: EMPTY+accept->ONE; ONE+accept+retire->ONE (output reloaded); ONE+accept only->FULL; ONE+retire only->EMPTY; FULL+retire->ONE (skid moves to output); all other combinations SHALL hold state.
REQ-022 in_ready SHALL equal (state != FULL), a function of registered state only; there SHALL be no combinational path from out_ready to in_ready.
REQ-023 out_valid SHALL equal (state != EMPTY); out_data/out_sel_err SHALL come directly from the output register.
REQ-024 Latency: a beat accepted in cycle N with state EMPTY SHALL be visible on out_* in cycle N+1.
REQ-025 Ordering: beats SHALL retire in acceptance order; no beat dropped or duplicated.
REQ-026 While out_valid && !out_ready, out_data and out_sel_err SHALL stay stable.
REQ-027 err_count SHALL increment by 1 on each accepted beat with sel_err = 1 and saturate at 2^ERR_CNT_W-1.
REQ-028 When err_clr coincides with an increment, clear SHALL win (err_count = 0 next cycle).

Reset
REQ-029 While rst_n = 0 at a clock edge: state SHALL become EMPTY; out_valid = 0, out_data = 0, out_sel_err = 0, err_count = 0; skid contents SHALL be zeroed.
REQ-030 in_ready SHALL be 1 in the cycle following reset.
REQ-031 Reset mid-operation SHALL discard all held beats without retiring them; no beat presented during a reset cycle is accepted.

Structure
REQ-032 Package fpu_mux_pkg SHALL hold the state enum (EMPTY/ONE/FULL) and a sel_width function (clog2 with a minimum of 1).
REQ-033 The selection logic SHALL be a combinational sub-module mux_nto1 (parameters NUM_INPUTS, DATA_WIDTH) with outputs data and sel_err, instantiated once.
REQ-034 Elaboration SHALL fail if NUM_INPUTS < 2 or NUM_INPUTS > 2^SEL_W.

Verification
REQ-035 After reset, in_sel = 1, slice1 = 0x3F800000, out_ready = 1 -> out_data = 0x3F800000 and out_valid one cycle later, out_sel_err = 0.
REQ-036 in_sel = 3 with NUM_INPUTS = 3 -> out_data = 0, out_sel_err = 1, err_count increments by 1.
REQ-037 out_ready = 0, three beats A,B,C offered -> A,B accepted, in_ready = 0 in FULL; then out_ready = 1 -> retires A,B,C in order, with data stable while stalled.
REQ-038 ERR_CNT_W = 8, 300 bad-select beats -> err_count = 255; err_clr coinciding with a bad beat -> err_count = 0.
REQ-039 State FULL, rst_n = 0 for one cycle -> out_valid = 0, in_ready = 1 next cycle, held beats never appear.
REQ-040 Random valid/ready back-pressure with 10k beats vs. scoreboard -> zero mismatches, order preserved, with NUM_INPUTS = 2, 3 and 16.

Source files
------------

// File: rtl/fpu_mux_pkg.sv
// Shared types for the operand select pipeline: buffer-occupancy states and
// the select-width helper used to size the binary source index.
package fpu_mux_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

    localparam int MIN_INPUTS = 2;
    localparam int MAX_INPUTS = 16;

    // A two-way select still needs one bit, so $clog2 is floored at 1.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nto1.sv
// Combinational N:1 operand select; out-of-range indices give zero data and
// raise sel_err. Zero latency, no flow control.
module mux_nto1 #(
    parameter int NUM_INPUTS = 3,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_W      = 2
) (
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]                 sel,
    output logic [DATA_WIDTH-1:0]            data,
    output logic                             sel_err
);

    always_comb begin
        data    = '0;
        sel_err = (int'(sel) >= NUM_INPUTS);
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (int'(sel) == k) begin
                data = in_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/operand_sel_pipe.sv
// Operand select with a two-entry output/skid buffer; accept-to-output latency 1.
// in_ready depends on registered occupancy only, so out_ready never reaches it combinationally.
module operand_sel_pipe
    import fpu_mux_pkg::*;
#(
    parameter int NUM_INPUTS = 3,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_W      = sel_width(NUM_INPUTS),
    parameter int ERR_CNT_W  = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]                 in_sel,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_sel_err,
    output logic                             out_valid,
    input  logic                             out_ready,
    input  logic                             err_clr,
    output logic [ERR_CNT_W-1:0]             err_count
);

    if (NUM_INPUTS < MIN_INPUTS || NUM_INPUTS > MAX_INPUTS ||
        NUM_INPUTS > (1 << SEL_W)) begin : g_bad_params
        $error("operand_sel_pipe: NUM_INPUTS=%0d unsupported with SEL_W=%0d",
               NUM_INPUTS, SEL_W);
    end

    pipe_state_t            r_state;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [DATA_WIDTH-1:0]  r_out_data;
    logic                   r_out_err;
    logic [DATA_WIDTH-1:0]  r_skid_data;
    logic                   r_skid_err;
    logic [ERR_CNT_W-1:0]   r_err_count;

    logic [DATA_WIDTH-1:0]  w_sel_data;
    logic                   w_sel_err;
    logic                   w_accept;
    logic                   w_retire;
    logic                   w_err_sat;

    mux_nto1 #(
        .NUM_INPUTS (NUM_INPUTS),
        .DATA_WIDTH (DATA_WIDTH),
        .SEL_W      (SEL_W)
    ) u_mux (
        .in_data (in_data),
        .sel     (in_sel),
        .data    (w_sel_data),
        .sel_err (w_sel_err)
    );

    assign w_accept  = in_valid && r_in_ready;
    assign w_retire  = r_out_valid && out_ready;
    assign w_err_sat = (r_err_count == {ERR_CNT_W{1'b1}});

    // Ready/valid flags are kept as registers alongside the state so both
    // handshake outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
            r_skid_data <= '0;
            r_skid_err  <= 1'b0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_out_data  <= w_sel_data;
                        r_out_err   <= w_sel_err;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_retire) begin
                        r_out_data <= w_sel_data;
                        r_out_err  <= w_sel_err;
                    end else if (w_accept) begin
                        r_skid_data <= w_sel_data;
                        r_skid_err  <= w_sel_err;
                        r_in_ready  <= 1'b0;
                        r_state     <= ST_FULL;
                    end else if (w_retire) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_retire) begin
                        r_out_data  <= r_skid_data;
                        r_out_err   <= r_skid_err;
                        r_skid_data <= '0;
                        r_skid_err  <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_ONE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_state     <= ST_EMPTY;
                end
            endcase

            // Clear has priority over a same-cycle bad-select increment.
            if (err_clr) begin
                r_err_count <= '0;
            end else if (w_accept && w_sel_err && !w_err_sat) begin
                r_err_count <= r_err_count + ERR_CNT_W'(1);
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_sel_err = r_out_err;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Drives three pipe instances (2, 3 and 16 sources) with shared stimulus and
// checks each against a bounded-queue reference model.
module tb_operand_sel_pipe;

    logic           clk;
    logic           rst_n;
    logic [511:0]   tb_in_data;
    logic [3:0]     tb_sel;
    logic           in_valid;
    logic           out_ready;
    logic           err_clr;

    logic [31:0]    o_data [3];
    logic           o_err  [3];
    logic           o_vld  [3];
    logic           o_rdy  [3];
    logic [7:0]     o_cnt  [3];

    int             m_ni   [3] = '{3, 2, 16};
    int             m_mask [3] = '{3, 1, 15};
    logic [32:0]    m_q    [3][2];
    int             m_cnt  [3];
    int             m_err  [3];
    logic           m_ret0;

    int             n_chk;
    int             n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NI = (g == 0) ? 3 : ((g == 1) ? 2 : 16);
        localparam int SW = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        operand_sel_pipe #(
            .NUM_INPUTS (NI),
            .DATA_WIDTH (32),
            .SEL_W      (SW),
            .ERR_CNT_W  (8)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_data     (tb_in_data[NI*32-1:0]),
            .in_sel      (tb_sel[SW-1:0]),
            .in_valid    (in_valid),
            .in_ready    (o_rdy[g]),
            .out_data    (o_data[g]),
            .out_sel_err (o_err[g]),
            .out_valid   (o_vld[g]),
            .out_ready   (out_ready),
            .err_clr     (err_clr),
            .err_count   (o_cnt[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, act, exp);
        end
    endtask

    // One clock: drive at negedge, advance the model, check at the next negedge.
    task automatic step(input logic v, input logic [3:0] s, input logic ordy,
                        input logic clr, input logic rst);
        logic [32:0] b;
        logic        acc;
        logic        ret;
        int          ss;
        in_valid  = v;
        tb_sel    = s;
        out_ready = ordy;
        err_clr   = clr;
        rst_n     = rst;
        for (int k = 0; k < 3; k++) begin
            acc = rst && v && (m_cnt[k] < 2);
            ret = rst && ordy && (m_cnt[k] > 0);
            if (k == 0) m_ret0 = ret;
            ss = int'(s) & m_mask[k];
            b  = (ss < m_ni[k]) ? {1'b0, tb_in_data[ss*32 +: 32]} : {1'b1, 32'h0};
            if (!rst) begin
                m_cnt[k] = 0;
                m_err[k] = 0;
            end else begin
                if (ret) begin
                    m_q[k][0] = m_q[k][1];
                    m_cnt[k]--;
                end
                if (acc) begin
                    m_q[k][m_cnt[k]] = b;
                    m_cnt[k]++;
                end
                if (clr) m_err[k] = 0;
                else if (acc && b[32] && m_err[k] < 255) m_err[k]++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("in_ready%0d", k), o_rdy[k], m_cnt[k] < 2);
            chk($sformatf("out_valid%0d", k), o_vld[k], m_cnt[k] > 0);
            chk($sformatf("err_count%0d", k), o_cnt[k], m_err[k]);
            if (m_cnt[k] > 0) begin
                chk($sformatf("out_data%0d", k), o_data[k], m_q[k][0][31:0]);
                chk($sformatf("out_sel_err%0d", k), o_err[k], m_q[k][0][32]);
            end
        end
    endtask

    initial begin
        logic [31:0] va, vb, vc;
        int nret, cyc;
        n_chk = 0;
        n_err = 0;
        m_ret0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0;
            m_err[k] = 0;
        end
        in_valid   = 1'b0;
        tb_sel     = '0;
        out_ready  = 1'b0;
        err_clr    = 1'b0;
        rst_n      = 1'b0;
        tb_in_data = '0;
        @(negedge clk);

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_data%0d", k), o_data[k], 32'h0);
            chk($sformatf("rst_err%0d", k), o_err[k], 1'b0);
        end
        step(0, 0, 1, 0, 1);

        for (int w = 0; w < 16; w++) tb_in_data[w*32 +: 32] = $urandom;
        tb_in_data[32 +: 32] = 32'h3F80_0000;
        step(1, 4'd1, 1, 0, 1);
        chk("lat_data", o_data[0], 32'h3F80_0000);
        chk("lat_vld", o_vld[0], 1'b1);
        chk("lat_err", o_err[0], 1'b0);

        step(1, 4'd3, 1, 0, 1);
        chk("bad_data", o_data[0], 32'h0);
        chk("bad_err", o_err[0], 1'b1);
        chk("bad_cnt", o_cnt[0], 8'd1);
        step(0, 0, 1, 0, 1);

        va = $urandom;
        vb = $urandom;
        vc = $urandom;
        tb_in_data[0 +: 32] = va;
        step(1, 0, 0, 0, 1);
        tb_in_data[0 +: 32] = vb;
        step(1, 0, 0, 0, 1);
        chk("full_rdy", o_rdy[0], 1'b0);
        chk("stall_a", o_data[0], va);
        tb_in_data[0 +: 32] = vc;
        step(1, 0, 0, 0, 1);
        chk("stall_rdy", o_rdy[0], 1'b0);
        chk("stall_hold", o_data[0], va);
        step(1, 0, 1, 0, 1);
        chk("ret_b", o_data[0], vb);
        chk("ret_rdy", o_rdy[0], 1'b1);
        step(1, 0, 1, 0, 1);
        chk("ret_c", o_data[0], vc);
        step(0, 0, 1, 0, 1);
        chk("drain", o_vld[0], 1'b0);

        repeat (300) step(1, 4'd3, 1, 0, 1);
        chk("sat_cnt", o_cnt[0], 8'd255);
        step(1, 4'd3, 1, 1, 1);
        chk("clr_cnt", o_cnt[0], 8'd0);
        step(0, 0, 1, 0, 1);

        step(1, 4'd0, 0, 0, 1);
        step(1, 4'd1, 0, 0, 1);
        chk("pre_rst_full", o_rdy[0], 1'b0);
        step(1, 4'd2, 0, 0, 0);
        chk("rst_vld", o_vld[0], 1'b0);
        chk("rst_rdy", o_rdy[0], 1'b1);
        step(0, 0, 1, 0, 1);
        chk("no_ghost", o_vld[0], 1'b0);

        nret = 0;
        cyc  = 0;
        while (nret < 10000 && cyc < 60000) begin
            for (int w = 0; w < 16; w++) tb_in_data[w*32 +: 32] = $urandom;
            step($urandom_range(0, 99) < 70, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 99) < 65, $urandom_range(0, 299) == 0,
                 $urandom_range(0, 2999) != 0);
            if (m_ret0) nret++;
            cyc++;
        end
        chk("rand_done", nret >= 10000, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
